// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin front end for a single-port synchronous memory shared by two
//   requesters. One request is accepted at a time. The block sequences the
//   memory write/read strobes, returns read data with a completion pulse, and
//   is the only block on the requester side that drives the shared data bus.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   req0/1, we0/1       request and direction (1 = write) per port
//   addr0/1, wdata0/1   request address and write data per port
//   gnt0/1              one-cycle pulse: request accepted
//   done0/1             one-cycle pulse: operation complete
//   rdata0/1            last read word per port (valid while done is high)
//   busy                high whenever a transaction is in flight
//   mem_wr, mem_rd      memory strobes (never high together)
//   mem_addr            memory address (holds its last value while idle)
//   mem_data            bidirectional memory bus; driven only in WRITE
module mem_arbiter #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0] wdata0,
   input  logic [DWIDTH-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DWIDTH-1:0] rdata0,
   output logic [DWIDTH-1:0] rdata1,
   output logic              busy,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [AWIDTH-1:0] mem_addr,
   inout  wire  [DWIDTH-1:0] mem_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ1 = 2'd2,
      ST_READ2 = 2'd3
   } state_t;

   state_t              state_reg;
   logic                owner_reg;    // port currently being served
   logic                last_reg;     // port served most recently
   logic [AWIDTH-1:0]   addr_reg;
   logic [DWIDTH-1:0]   wdata_reg;
   logic                gnt0_reg;
   logic                gnt1_reg;
   logic                done0_reg;
   logic                done1_reg;
   logic [DWIDTH-1:0]   rdata0_reg;
   logic [DWIDTH-1:0]   rdata1_reg;

   // Winner selection: port 1 wins if it is the only requester, or if both
   // request and port 0 was served last.
   logic sel1_next;
   logic sel_we_next;

   always_comb begin
      sel1_next   = req1 && (!req0 || !last_reg);
      sel_we_next = sel1_next ? we1 : we0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         owner_reg  <= 1'b0;
         last_reg   <= 1'b1;          // port 0 wins the first tie
         addr_reg   <= '0;
         wdata_reg  <= '0;
         gnt0_reg   <= 1'b0;
         gnt1_reg   <= 1'b0;
         done0_reg  <= 1'b0;
         done1_reg  <= 1'b0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
      end else begin
         // Pulses default low; each is set for exactly one cycle below.
         gnt0_reg  <= 1'b0;
         gnt1_reg  <= 1'b0;
         done0_reg <= 1'b0;
         done1_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (req0 || req1) begin
                  owner_reg <= sel1_next;
                  last_reg  <= sel1_next;
                  addr_reg  <= sel1_next ? addr1  : addr0;
                  wdata_reg <= sel1_next ? wdata1 : wdata0;
                  gnt0_reg  <= !sel1_next;
                  gnt1_reg  <= sel1_next;
                  state_reg <= sel_we_next ? ST_WRITE : ST_READ1;
               end
            end

            ST_WRITE: begin
               done0_reg <= !owner_reg;
               done1_reg <= owner_reg;
               state_reg <= ST_IDLE;
            end

            // Memory registers the word at the end of READ1 and drives it
            // onto the bus during READ2, so the capture happens here.
            ST_READ1: begin
               state_reg <= ST_READ2;
            end

            ST_READ2: begin
               if (owner_reg) begin
                  rdata1_reg <= mem_data;
                  done1_reg  <= 1'b1;
               end else begin
                  rdata0_reg <= mem_data;
                  done0_reg  <= 1'b1;
               end
               state_reg <= ST_IDLE;
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // All outputs come straight from registers or from a decode of the state
   // register, so nothing combinational from the request inputs reaches a pin.
   assign gnt0     = gnt0_reg;
   assign gnt1     = gnt1_reg;
   assign done0    = done0_reg;
   assign done1    = done1_reg;
   assign rdata0   = rdata0_reg;
   assign rdata1   = rdata1_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign mem_wr   = (state_reg == ST_WRITE);
   assign mem_rd   = (state_reg == ST_READ1) || (state_reg == ST_READ2);
   assign mem_addr = addr_reg;
   assign mem_data = (state_reg == ST_WRITE) ? wdata_reg : {DWIDTH{1'bz}};

endmodule
